// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit and memory.
//   master : LSU side. Drives req/we/addr/be/wdata and samples ack/rdata.
//   slave  : memory side. Samples the request and drives ack/rdata.
// rdata is valid in the same cycle that ack is high.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit. It performs one aligned byte, half or word access per
// instruction over a req/ack word bus, and stalls the core until the access finishes.
//   clk, rst         : clock, asynchronous active-high reset
//   start_i          : memory instruction in execute (qualified by mem_read_i/mem_write_i)
//   mem_read_i       : load
//   mem_write_i      : store (wins over mem_read_i)
//   funct3_i         : width/sign code
//   addr_i           : effective address
//   store_data_i     : rs2 value
//   busy_o           : stall request (combinational)
//   done_o           : one-cycle completion pulse
//   fault_o          : misaligned or illegal funct3, valid with done_o
//   load_data_o      : extended load result, held until the next done_o
//   bus_if           : memory bus (master side)
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [31:0]       load_data_o,
  load_store_unit_if.master bus_if
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic              fault_q;
  logic [31:0]       load_data_q;

  logic        req_valid;
  logic        bad;
  logic        go_req;
  logic        go_fault;
  logic        ack_hit;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_valid = start_i & (mem_read_i | mem_write_i);

  // Request decode: fault check, byte enables and lane-replicated write data.
  always_comb begin
    bad     = 1'b0;
    be_d    = 4'b0000;
    wdata_d = store_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        bad     = addr_i[0];
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        bad  = (addr_i[1:0] != 2'b00);
        be_d = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
    // Unsigned variants exist only for byte/half loads.
    if (funct3_i[2] && (mem_write_i || funct3_i[1])) begin
      bad = 1'b1;
    end
  end

  assign go_req   = (state_q == StIdle) & req_valid & ~bad;
  assign go_fault = (state_q == StIdle) & req_valid & bad;
  assign ack_hit  = (state_q == StReq) & bus_if.bus_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (go_req) begin
          state_d = StReq;
        end else if (go_fault) begin
          state_d = StDone;
        end
      end
      StReq: begin
        if (bus_if.bus_ack) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Align the addressed lane to bit 0, then extend.
  assign shifted = bus_if.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = bus_if.bus_rdata;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = bus_if.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr_q  <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      fault_q     <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      if (go_req) begin
        bus_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
        be_q       <= be_d;
        wdata_q    <= wdata_d;
        we_q       <= mem_write_i;
        off_q      <= addr_i[1:0];
        funct3_q   <= funct3_i;
        fault_q    <= 1'b0;
      end
      if (go_fault) begin
        fault_q     <= 1'b1;
        load_data_q <= 32'h0;
      end
      // Stores leave the previous load result untouched.
      if (ack_hit && !we_q) begin
        load_data_q <= load_ext;
      end
    end
  end

  assign busy_o      = ((state_q == StIdle) & req_valid) | (state_q == StReq);
  assign done_o      = (state_q == StDone);
  assign fault_o     = fault_q;
  assign load_data_o = load_data_q;

  assign bus_if.bus_req   = (state_q == StReq);
  assign bus_if.bus_we    = we_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_be    = be_q;
  assign bus_if.bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;

  load_store_unit_if #(.ADDR_W(32)) bus_if ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .busy_o       (busy),
    .done_o       (done),
    .fault_o      (fault),
    .load_data_o  (load_data),
    .bus_if       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int          n_cmp;
  int          n_err;
  logic [31:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    mem_write  = v.st;
    mem_read   = ~v.st;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    #1;
    check($sformatf("v%0d busy_on_start", idx), {31'h0, busy}, 32'h1);
    if (busy) busy_cnt++;
    @(negedge clk);
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (v.flt) begin
      check($sformatf("v%0d fault_done", idx), {31'h0, done}, 32'h1);
      check($sformatf("v%0d fault_flag", idx), {31'h0, fault}, 32'h1);
      check($sformatf("v%0d fault_noreq", idx), {31'h0, bus_if.bus_req}, 32'h0);
      check($sformatf("v%0d fault_busy", idx), {31'h0, busy}, 32'h0);
      held = 32'h0;
      check($sformatf("v%0d fault_ld", idx), load_data, held);
    end else begin
      for (int k = 0; k <= v.waits; k++) begin
        check($sformatf("v%0d req%0d", idx, k), {31'h0, bus_if.bus_req}, 32'h1);
        check($sformatf("v%0d nodone%0d", idx, k), {31'h0, done}, 32'h0);
        check($sformatf("v%0d addr%0d", idx, k), bus_if.bus_addr, v.baddr);
        check($sformatf("v%0d be%0d", idx, k), {28'h0, bus_if.bus_be}, {28'h0, v.be});
        check($sformatf("v%0d we%0d", idx, k), {31'h0, bus_if.bus_we}, {31'h0, v.st});
        if (v.st) check($sformatf("v%0d wdata%0d", idx, k), bus_if.bus_wdata, v.wdata);
        if (busy) busy_cnt++;
        if (k == v.waits) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = v.rdata;
        end
        @(negedge clk);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
      end
      check($sformatf("v%0d done", idx), {31'h0, done}, 32'h1);
      check($sformatf("v%0d fault", idx), {31'h0, fault}, 32'h0);
      check($sformatf("v%0d done_noreq", idx), {31'h0, bus_if.bus_req}, 32'h0);
      check($sformatf("v%0d done_busy", idx), {31'h0, busy}, 32'h0);
      if (!v.st) held = v.ld;
      check($sformatf("v%0d load_data", idx), load_data, held);
      check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.waits + 2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    held  = 32'h0;
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;

    //            st  f3      addr          sd            rdata         w  flt be       baddr         wdata         ld
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,        0, 1'b0, 4'b0010, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0};
    vecs[3]  = '{1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        1, 1'b0, 4'b1111, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h0000_0005, 32'h1234_5678, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1111, 1, 1'b0, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
    vecs[8]  = '{1'b0, 3'b100, 32'h0000_0041, 32'h0,        32'h0000_C300, 0, 1'b0, 4'b0010, 32'h0000_0040, 32'h0,        32'h0000_00C3};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'h1234_5678, 0, 1'b0, 4'b1111, 32'h0000_0000, 32'h0,        32'h1234_5678};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 4'b1111, 32'h0000_0004, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 32'h0,        2, 1'b0, 4'b1100, 32'h0000_0004, 32'hABCD_ABCD, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_0008, 32'h0000_0011, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[13] = '{1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};

    // Reset values.
    #3;
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst done", {31'h0, done}, 32'h0);
    check("rst fault", {31'h0, fault}, 32'h0);
    check("rst req", {31'h0, bus_if.bus_req}, 32'h0);
    check("rst we", {31'h0, bus_if.bus_we}, 32'h0);
    check("rst addr", bus_if.bus_addr, 32'h0);
    check("rst be", {28'h0, bus_if.bus_be}, 32'h0);
    check("rst wdata", bus_if.bus_wdata, 32'h0);
    check("rst load_data", load_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors; each starts in the cycle right after the previous DONE.
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // Stray ack in IDLE must not disturb anything.
    @(negedge clk);
    check("idle nodone", {31'h0, done}, 32'h0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("stray req%0d", k), {31'h0, bus_if.bus_req}, 32'h0);
      check($sformatf("stray done%0d", k), {31'h0, done}, 32'h0);
      check($sformatf("stray busy%0d", k), {31'h0, busy}, 32'h0);
      check($sformatf("stray ld%0d", k), load_data, held);
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset in the middle of a REQ, then a late ack.
    @(negedge clk);
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0;
    check("rreq req", {31'h0, bus_if.bus_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rreq async drop", {31'h0, bus_if.bus_req}, 32'h0);
    check("rreq busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    held = 32'h0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rreq nodone%0d", k), {31'h0, done}, 32'h0);
      check($sformatf("rreq noreq%0d", k), {31'h0, bus_if.bus_req}, 32'h0);
      check($sformatf("rreq ld%0d", k), load_data, 32'h0);
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Normal access after the abandoned one.
    run_vec(100, vecs[0]);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit directly downstream of the ALU in the single-cycle core. It takes the ALU result as the effective address and rs2 data as store data, and performs one aligned byte, half or word access on a word-wide memory bus with a req/ack handshake. It stalls the core via `busy` until the access completes, and returns sign/zero-extended load data. Misaligned addresses and illegal width codes are faulted without touching the bus.

## Interface
- ADDR_W, 32, effective address / bus address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  memory instruction present in execute; only qualified when mem_read or mem_write is high
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction; has priority if both are high
- funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores)
- addr  in  ADDR_W  effective address (ALU result)
- store_data  in  32  rs2 value
- busy  out  1  stall request to core
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; misaligned address or illegal funct3
- load_data  out  32  extended load result, valid with done, held until the next done
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete; rdata valid in the same cycle
- bus_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Request qualified as `start & (mem_read | mem_write)`.
  - On a qualified request, latch addr, funct3, we = mem_write, and store_data.
  - Check validity:
    - Half access faults if addr[0] = 1.
    - Word access faults if addr[1:0] != 0.
    - funct3 ∈ {011, 110, 111} faults.
    - Any store with funct3[2] = 1 faults.
  - Fault: go to DONE with fault = 1 and load_data = 0. No bus activity.
  - Otherwise go to REQ.
- REQ:
  - bus_req = 1; bus_we, bus_addr, bus_be and bus_wdata are driven from the latched values and held stable.
  - Stay in REQ until bus_ack = 1 is sampled, then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 if addr[1] = 0, else 4'b1100.
  - Word: 4'b1111.
  - The same enables are used for reads.
- Write data:
  - sb: {4{sd[7:0]}}.
  - sh: {2{sd[15:0]}}.
  - sw: sd.
- Load data:
  - Capture from bus_rdata on the ack edge, shifted right by 8×addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
- bus_ack outside REQ is ignored.

## Timing
- Reset values: state IDLE; busy, done, fault, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, load_data = 0.
- busy = (IDLE & qualified start) | REQ. This is combinational so the core stalls in the same cycle the instruction appears. busy is low in DONE, and the core advances on the DONE edge.
- done, fault, load_data and all bus outputs are registered or decoded from state only. No combinational path from bus_ack to the bus outputs.
- Latency, with start sampled at edge T:
  - bus_req is high during cycle T+1.
  - If ack arrives in T+1, done is high in T+2.
  - Each extra wait cycle adds one cycle.
- Faulted access: done is high in T+1, with no bus_req.
- Back-to-back: a new qualified start in the cycle after DONE is accepted. Throughput is at best one access per 3 cycles.
- Reset mid-REQ: bus_req drops asynchronously, the access is abandoned, and no done pulse is issued. A bus_ack arriving after reset is ignored.
- start deasserted while in REQ: the access still completes.

## Test plan
- Reset mid-REQ: assert rst during REQ before ack -> bus_req drops immediately, no done pulse, and the next access works normally.
- Load byte sign-extend: lb addr=0x1003, rdata=0x80FF1234, ack on first REQ cycle -> bus_addr=0x1000, be=1000, done 2 cycles after start, load_data=0xFFFFFF80, fault=0.
- Load half zero-extend with wait states: lhu addr=0x2002, rdata=0xBEEF0000, ack after 3 wait cycles -> be=1100, busy high for 5 cycles, load_data=0x0000BEEF.
- Store byte and store word:
  - sb addr=0x11, sd=0x000000A5 -> we=1, be=0010, wdata=0xA5A5A5A5.
  - sw addr=0x20, sd=0xDEADBEEF -> be=1111, wdata=0xDEADBEEF.
- Faults without bus activity:
  - lw addr=0x1002 -> done one cycle after start, fault=1, bus_req never high.
  - sh addr=0x5 -> done one cycle after start, fault=1, bus_req never high.
  - funct3=011 load -> done one cycle after start, fault=1, bus_req never high.
- Back-to-back and stray ack:
  - lw 0x0 followed immediately by sw 0x4 -> both complete and load_data is held through the store's done.
  - bus_ack pulsed in IDLE -> no effect.
